// File: rtl/fl2int_seq.sv
// Sequential float-to-integer converter: operand {s, e, m} = (-1)^s * m * 2^e, one shift per cycle.
// Defining FL2INT_SAT_EN saturates out on overflow; otherwise out wraps modulo 2^NUBITS.
module fl2int_seq #(
    parameter int EXP    = 8,
    parameter int MAN    = 23,
    parameter int NUBITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MAN+EXP:0]       in,
    output logic                   busy,
    output logic                   done,
    output logic [NUBITS-1:0]      out,
    output logic                   ovf
);

    localparam int KW = $clog2(NUBITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUBITS:0]     acc_q;
    logic [KW-1:0]       k_q;
    logic                left_q;
    logic                neg_q;
    logic                sticky_q;
    logic [NUBITS-1:0]   out_q;
    logic                ovf_q;
    logic                done_q;

    logic                in_s;
    logic signed [EXP-1:0] e_s;
    logic [MAN-1:0]      in_m;
    int                  e_int;

    logic [NUBITS:0]     acc_ld_d;
    logic [KW-1:0]       k_ld_d;
    logic                sticky_ld_d;
    logic                ovf_d;
    logic [NUBITS-1:0]   res_d;

    assign in_s  = in[MAN+EXP];
    assign e_s   = in[MAN+EXP-1:MAN];
    assign in_m  = in[MAN-1:0];
    assign e_int = int'(e_s);

    // Exponents outside the shiftable window collapse to a zero accumulator; a too-large
    // exponent with a non-zero mantissa is flagged as overflow from the start.
    always_comb begin
        acc_ld_d    = (NUBITS+1)'(in_m);
        k_ld_d      = '0;
        sticky_ld_d = 1'b0;
        if (e_int >= 0 && e_int <= NUBITS-1) begin
            k_ld_d = KW'(e_int);
        end else if (e_int < 0 && e_int > -MAN) begin
            k_ld_d = KW'(-e_int);
        end else if (e_int >= NUBITS) begin
            acc_ld_d    = '0;
            sticky_ld_d = (in_m != '0);
        end else begin
            acc_ld_d = '0;
        end
    end

    // Magnitude >= 2^(NUBITS-1) overflows, including the exactly-representable -2^(NUBITS-1).
    always_comb begin
        ovf_d = sticky_q | acc_q[NUBITS] | acc_q[NUBITS-1];
        res_d = neg_q ? -acc_q[NUBITS-1:0] : acc_q[NUBITS-1:0];
`ifdef FL2INT_SAT_EN
        if (ovf_d) begin
            res_d = neg_q ? {1'b1, {(NUBITS-1){1'b0}}} : {1'b0, {(NUBITS-1){1'b1}}};
        end
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            k_q      <= '0;
            left_q   <= 1'b0;
            neg_q    <= 1'b0;
            sticky_q <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SHIFT;
                        acc_q    <= acc_ld_d;
                        k_q      <= k_ld_d;
                        left_q   <= (e_int >= 0);
                        neg_q    <= in_s;
                        sticky_q <= sticky_ld_d;
                    end
                end
                SHIFT: begin
                    if (k_q == '0) begin
                        state_q <= DONE;
                        out_q   <= res_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_q - 1'b1;
                        if (left_q) begin
                            acc_q    <= {acc_q[NUBITS-1:0], 1'b0};
                            sticky_q <= sticky_q | acc_q[NUBITS];
                        end else begin
                            acc_q <= {1'b0, acc_q[NUBITS:1]};
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule
